// File: rtl/patmos.sv
// patmos: UART echo unit (8N1 receiver, one-byte holding buffer, transmitter, last-byte LEDs, byte counter)
module patmos #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_uartPins_rx,
  output logic        io_uartPins_tx,
  output logic [7:0]  io_led,
  output logic [31:0] io_dummy
);
  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int TW = $clog2(DIV);
  localparam logic [TW-1:0] FULL = TW'(DIV - 1);
  localparam logic [TW-1:0] HALF = TW'(DIV / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t rs, ts;
  logic s1, s2, armed, full, rd, wr, rx_ok;
  logic [1:0] live;
  logic [TW-1:0] rt, tt;
  logic [2:0] rn, tn;
  logic [7:0] rsh, tsh, hold;
  assign rx_ok = rs == STOP && rt == '0 && s2;
  assign rd = full && (ts == IDLE || (ts == STOP && tt == '0));
  assign wr = rx_ok && (!full || rd);
  // live marks when s2 holds a real line sample; armed needs the line seen high before hunting
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      live <= '0;
      armed <= 1'b0;
      rs <= IDLE;
      rt <= '0;
      rn <= '0;
      rsh <= '0;
      io_led <= '0;
      io_dummy <= '0;
    end else begin
      s1 <= io_uartPins_rx;
      s2 <= s1;
      live <= {live[0], 1'b1};
      armed <= armed | (live[1] & s2);
      case (rs)
        IDLE: if (armed && !s2) begin
          rs <= START;
          rt <= HALF;
        end
        START: if (rt == '0) begin
          rs <= s2 ? IDLE : DATA;
          rt <= s2 ? '0 : FULL;
          rn <= '0;
        end else rt <= rt - TW'(1);
        DATA: if (rt == '0) begin
          rsh <= {s2, rsh[7:1]};
          rn <= rn + 3'd1;
          rt <= FULL;
          rs <= rn == 3'd7 ? STOP : DATA;
        end else rt <= rt - TW'(1);
        default: if (rt == '0) begin
          rs <= IDLE;
          armed <= s2;
          if (s2) begin
            io_led <= rsh;
            io_dummy <= io_dummy + 32'd1;
          end
        end else rt <= rt - TW'(1);
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      hold <= '0;
      ts <= IDLE;
      tt <= '0;
      tn <= '0;
      tsh <= '0;
      io_uartPins_tx <= 1'b1;
    end else begin
      full <= wr | (full & ~rd);
      if (wr) hold <= rsh;
      case (ts)
        IDLE: if (full) begin
          ts <= START;
          tsh <= hold;
          tt <= FULL;
          io_uartPins_tx <= 1'b0;
        end
        START: if (tt == '0) begin
          ts <= DATA;
          tt <= FULL;
          tn <= '0;
          io_uartPins_tx <= tsh[0];
          tsh <= tsh >> 1;
        end else tt <= tt - TW'(1);
        DATA: if (tt == '0) begin
          tt <= FULL;
          tn <= tn + 3'd1;
          ts <= tn == 3'd7 ? STOP : DATA;
          io_uartPins_tx <= tn == 3'd7 ? 1'b1 : tsh[0];
          tsh <= tsh >> 1;
        end else tt <= tt - TW'(1);
        default: if (tt == '0) begin
          ts <= full ? START : IDLE;
          tt <= full ? FULL : '0;
          io_uartPins_tx <= !full;
          if (full) tsh <= hold;
        end else tt <= tt - TW'(1);
      endcase
    end
  end
endmodule

// File: tb/tb_patmos.sv
// tb_patmos: directed frames on rx, mid-stop checks of io_led/io_dummy, and a tx frame decoder
module tb_patmos;
  localparam int DIV = 868;
  logic clk = 1'b0, reset = 1'b1, rx = 1'b1, tx;
  logic [7:0] led;
  logic [31:0] cnt;
  int checks = 0, failures = 0, cyc = 0;
  logic [7:0] tx_q[$];
  bit tx_bad[$];
  int starts[$];
  int n0;
  patmos dut (
    .clk(clk),
    .reset(reset),
    .io_uartPins_rx(rx),
    .io_uartPins_tx(tx),
    .io_led(led),
    .io_dummy(cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Decode each tx frame; a bit must hold the same value at its first and last clock.
  initial forever begin
    logic [7:0] d;
    logic v0, v1;
    bit bad;
    @(negedge tx);
    starts.push_back(cyc);
    d = '0;
    bad = 1'b0;
    for (int b = 0; b < 10; b++) begin
      @(negedge clk);
      v0 = tx;
      repeat (DIV - 1) @(negedge clk);
      v1 = tx;
      if (v0 !== v1 || (b == 0 && v0 !== 1'b0) || (b == 9 && v0 !== 1'b1)) bad = 1'b1;
      if (b >= 1 && b <= 8) d[b-1] = v0;
    end
    tx_q.push_back(d);
    tx_bad.push_back(bad);
  end
  task automatic send_byte(input logic [7:0] d, input logic sb, input logic [7:0] el,
                           input logic [31:0] ec, input string tag);
    logic [9:0] f;
    f = {sb, d, 1'b0};
    for (int i = 0; i < 9; i++) begin
      rx = f[i];
      repeat (DIV) @(negedge clk);
    end
    rx = f[9];
    repeat (DIV / 2 + 10) @(negedge clk);
    check({tag, "_led"}, 32'(led), 32'(el));
    check({tag, "_cnt"}, cnt, ec);
    repeat (DIV / 2 - 10) @(negedge clk);
    rx = 1'b1;
  endtask
  initial begin
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_led", 32'(led), 32'd0);
      check("rst_cnt", cnt, 32'd0);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'hAA, 1'b1, 8'hAA, 32'd1, "aa");
    rx = 1'b0;
    repeat (200) @(negedge clk);
    rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    check("glitch_led", 32'(led), 32'hAA);
    check("glitch_cnt", cnt, 32'd1);
    send_byte(8'h55, 1'b0, 8'hAA, 32'd1, "ferr");
    repeat (DIV) @(negedge clk);
    check("echo_starts", 32'(starts.size()), 32'd1);
    check("echo_count", 32'(tx_q.size()), 32'd1);
    check("echo_byte", 32'(tx_q[0]), 32'hAA);
    check("echo_shape", 32'(tx_bad[0]), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst2_led", 32'(led), 32'd0);
    check("rst2_cnt", cnt, 32'd0);
    check("rst2_tx", 32'(tx), 32'd1);
    reset = 1'b0;
    tx_q.delete();
    tx_bad.delete();
    starts.delete();
    repeat (4) @(negedge clk);
    send_byte(8'h01, 1'b1, 8'h01, 32'd1, "b2b1");
    send_byte(8'h02, 1'b1, 8'h02, 32'd2, "b2b2");
    send_byte(8'h03, 1'b1, 8'h03, 32'd3, "b2b3");
    repeat (11 * DIV) @(negedge clk);
    check("b2b_starts", 32'(starts.size()), 32'd3);
    check("b2b_count", 32'(tx_q.size()), 32'd3);
    check("b2b_byte0", 32'(tx_q[0]), 32'h01);
    check("b2b_byte1", 32'(tx_q[1]), 32'h02);
    check("b2b_byte2", 32'(tx_q[2]), 32'h03);
    check("b2b_shape", 32'(tx_bad[0] | tx_bad[1] | tx_bad[2]), 32'd0);
    check("b2b_gap01", 32'(starts[1] - starts[0]), 32'(10 * DIV));
    check("b2b_gap12", 32'(starts[2] - starts[1]), 32'(10 * DIV));
    send_byte(8'hF0, 1'b1, 8'hF0, 32'd4, "mid");
    repeat (DIV) @(negedge clk);
    check("mid_tx_low", 32'(tx), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_led", 32'(led), 32'd0);
    check("mid_rst_cnt", cnt, 32'd0);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    n0 = starts.size();
    reset = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    rx = 1'b1;
    repeat (10 * DIV) @(negedge clk);
    check("lowrst_cnt", cnt, 32'd0);
    check("lowrst_led", 32'(led), 32'd0);
    check("lowrst_tx", 32'(starts.size()), 32'(n0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
